// File: rtl/loopback_fifo.sv
// Byte elastic buffer between the usb_cdc OUT and IN streams, with a registered FWFT output,
// a fill level and a retriggerable activity pulse for the board LED.
module loopback_fifo #(
  parameter int DEPTH      = 16,
  parameter int ACT_CYCLES = 1600000
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic [7:0]                 rx_data_i,
  input  logic                       rx_valid_i,
  output logic                       rx_ready_o,
  output logic [7:0]                 tx_data_o,
  output logic                       tx_valid_o,
  input  logic                       tx_ready_i,
  output logic [$clog2(DEPTH+1)-1:0] level_o,
  output logic                       activity_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);
  localparam int CW = $clog2(ACT_CYCLES+1);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] ram_count;
  logic [CW-1:0] act_cnt;
  logic          push;
  logic          pop;
  logic          load;

  assign rx_ready_o = ~flush_i & (level_o < LW'(DEPTH));
  assign push       = rx_valid_i & rx_ready_o;
  assign pop        = tx_valid_o & tx_ready_i & ~flush_i;

  // level_o counts the output register too; the RAM holds the rest.
  assign ram_count  = level_o - LW'(tx_valid_o);
  assign load       = ~flush_i & (~tx_valid_o | pop) & (ram_count != '0);

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr] <= rx_data_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level_o    <= '0;
      tx_valid_o <= 1'b0;
      tx_data_o  <= 8'h00;
    end else if (flush_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level_o    <= '0;
      tx_valid_o <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (load) begin
        tx_data_o  <= mem[rd_ptr];
        tx_valid_o <= 1'b1;
        rd_ptr     <= rd_ptr + AW'(1);
      end else if (pop) begin
        tx_valid_o <= 1'b0;
      end
      if (push && !pop) begin
        level_o <= level_o + LW'(1);
      end else if (pop && !push) begin
        level_o <= level_o - LW'(1);
      end
    end
  end

  // Activity stays high for exactly ACT_CYCLES cycles after the last transfer.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      act_cnt    <= '0;
      activity_o <= 1'b0;
    end else if (push || pop) begin
      act_cnt    <= CW'(ACT_CYCLES - 1);
      activity_o <= 1'b1;
    end else if (act_cnt != '0) begin
      act_cnt <= act_cnt - CW'(1);
    end else begin
      activity_o <= 1'b0;
    end
  end

endmodule
